// File: rtl/leak_collector_256_pkg.sv
// Shared definitions for the leaked-key collector.
//   state_t  : 2-bit FSM state encoding (IDLE, ARMED, COLLECT, DONE)
//   KEY_W    : width of the reassembled key (256 bits)
//   SYM_W    : width of one leaked symbol (2 bits)
//   NSYM_DEF : default number of symbols per key frame (KEY_W / SYM_W)
package leak_collector_256_pkg;

  localparam int KEY_W    = 256;
  localparam int SYM_W    = 2;
  localparam int NSYM_DEF = KEY_W / SYM_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_COLLECT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/leak_collector_256_shift_reg.sv
// Right-shifting symbol register: each enabled cycle the new symbol enters at
// the top and everything moves down by one symbol, so after a full frame the
// first symbol received sits in the lowest bits.
//   clk : clock, rising edge
//   clr : synchronous clear (wins over en)
//   en  : shift enable
//   sym : incoming symbol
//   key : current register contents
module leak_shift_reg
  import leak_collector_256_pkg::*;
#(
  parameter int KEY_W_P = KEY_W,
  parameter int SYM_W_P = SYM_W
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic [SYM_W_P-1:0] sym,
  output logic [KEY_W_P-1:0] key
);

  always_ff @(posedge clk) begin
    if (clr) begin
      key <= '0;
    end else if (en) begin
      key <= {sym, key[KEY_W_P-1:SYM_W_P]};
    end
  end

endmodule

// File: rtl/leak_collector_256.sv
// Collects a 256-bit key leaked two bits at a time and presents it with a
// valid/ack handshake. A gap watchdog aborts frames that stall too long, and
// sticky flags record aborted frames and symbols arriving while a completed
// key is still waiting for acknowledgement.
//   clk         : clock, rising edge
//   rst_all_n   : synchronous active-low reset
//   start       : arm request, honoured only in IDLE
//   sym_valid   : sym carries a symbol this cycle
//   sym         : leaked symbol, first symbol = key bits [1:0]
//   key_ack     : consumer takes key_out (only meaningful in DONE)
//   key_out     : live shift register contents
//   key_valid   : key_out is a complete frame (DONE)
//   busy        : ARMED or COLLECT
//   err_gap     : sticky, a frame was aborted by the watchdog
//   err_overrun : sticky, a symbol arrived in DONE
module leak_collector_256
  import leak_collector_256_pkg::*;
#(
  parameter int NSYM    = NSYM_DEF,
  parameter int GAP_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_all_n,
  input  logic             start,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym,
  input  logic             key_ack,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err_gap,
  output logic             err_overrun
);

  localparam int GAP_W = $clog2(GAP_MAX + 1);

  state_t           state, state_nx;
  logic [7:0]       count;
  logic [GAP_W-1:0] gap;
  logic             shift_en;
  logic             clr_key;
  logic             set_gap;
  logic             set_ovr;

  // Next-state and per-cycle strobes
  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    clr_key  = 1'b0;
    set_gap  = 1'b0;
    set_ovr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_ARMED;
          clr_key  = 1'b1;
        end
      end
      S_ARMED: begin
        if (sym_valid) begin
          shift_en = 1'b1;
          state_nx = (NSYM == 1) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (sym_valid) begin
          shift_en = 1'b1;
          // count holds symbols already taken; this one completes the frame
          if (count == 8'(NSYM - 1)) begin
            state_nx = S_DONE;
          end
        end else if (gap == GAP_W'(GAP_MAX - 1)) begin
          // this idle cycle is the GAP_MAX-th in a row
          state_nx = S_IDLE;
          set_gap  = 1'b1;
          clr_key  = 1'b1;
        end
      end
      S_DONE: begin
        if (sym_valid) begin
          set_ovr = 1'b1;
        end
        if (key_ack) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, counters and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_all_n) begin
      state       <= S_IDLE;
      count       <= '0;
      gap         <= '0;
      err_gap     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (clr_key) begin
        count <= '0;
        gap   <= '0;
      end else if (shift_en) begin
        count <= (state == S_ARMED) ? 8'd1 : count + 8'd1;
        gap   <= '0;
      end else if (state == S_COLLECT) begin
        gap <= gap + GAP_W'(1);
      end
      if (set_gap) begin
        err_gap <= 1'b1;
      end
      if (set_ovr) begin
        err_overrun <= 1'b1;
      end
    end
  end

  leak_shift_reg #(
    .KEY_W_P (KEY_W),
    .SYM_W_P (SYM_W)
  ) u_shift (
    .clk (clk),
    .clr (clr_key | ~rst_all_n),
    .en  (shift_en),
    .sym (sym),
    .key (key_out)
  );

  assign key_valid = (state == S_DONE);
  assign busy      = (state == S_ARMED) || (state == S_COLLECT);

endmodule

// File: tb/tb_leak_collector_256.sv
module tb_leak_collector_256;

  logic         clk = 1'b0;
  logic         rst_all_n;
  logic         start;
  logic         sym_valid;
  logic [1:0]   sym;
  logic         key_ack;
  logic [255:0] key_out;
  logic         key_valid;
  logic         busy;
  logic         err_gap;
  logic         err_overrun;

  int n_chk  = 0;
  int n_pass = 0;

  logic [255:0] k1;
  logic [255:0] k2;
  logic         kv_seen;

  leak_collector_256 dut (
    .clk         (clk),
    .rst_all_n   (rst_all_n),
    .start       (start),
    .sym_valid   (sym_valid),
    .sym         (sym),
    .key_ack     (key_ack),
    .key_out     (key_out),
    .key_valid   (key_valid),
    .busy        (busy),
    .err_gap     (err_gap),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Arm and send a full frame of k; gap_every>0 inserts 3 idle cycles after
  // every gap_every-th symbol. Returns with the last symbol just sampled.
  task automatic send_frame(input logic [255:0] k, input int gap_every);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("armed_busy", {255'd0, busy}, 256'd1);
    for (int i = 0; i < 128; i++) begin
      sym_valid = 1'b1;
      sym       = k[2*i +: 2];
      tick();
      if (i == 126) chk("kv_before_last", {255'd0, key_valid}, 256'd0);
      if (gap_every > 0 && ((i + 1) % gap_every) == 0 && i != 127) begin
        sym_valid = 1'b0;
        repeat (3) tick();
      end
    end
    sym_valid = 1'b0;
  endtask

  task automatic do_ack();
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
  endtask

  initial begin
    k1 = {4{64'h0123_4567_89AB_CDEF}};
    k2 = {8{32'hFFFF_0000}};
    rst_all_n = 1'b0;
    start     = 1'b0;
    sym_valid = 1'b0;
    sym       = 2'd0;
    key_ack   = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_key", key_out, 256'd0);
    chk("rst_kv", {255'd0, key_valid}, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_egap", {255'd0, err_gap}, 256'd0);
    chk("rst_eovr", {255'd0, err_overrun}, 256'd0);
    rst_all_n = 1'b1;
    tick();

    // Full frame
    send_frame(k1, 0);
    chk("full_kv", {255'd0, key_valid}, 256'd1);
    chk("full_key", key_out, k1);
    chk("full_busy", {255'd0, busy}, 256'd0);
    tick();
    chk("full_hold_key", key_out, k1);
    chk("full_hold_kv", {255'd0, key_valid}, 256'd1);
    do_ack();
    chk("full_ack_kv", {255'd0, key_valid}, 256'd0);
    chk("full_ack_busy", {255'd0, busy}, 256'd0);

    // Gappy frame: 3 idles after every 10th symbol
    send_frame(k1, 10);
    chk("gappy_kv", {255'd0, key_valid}, 256'd1);
    chk("gappy_key", key_out, k1);
    chk("gappy_egap", {255'd0, err_gap}, 256'd0);
    do_ack();

    // Overrun: two symbols while waiting for ack
    send_frame(k2, 0);
    sym_valid = 1'b1;
    sym       = 2'd1;
    tick();
    sym = 2'd2;
    tick();
    sym_valid = 1'b0;
    chk("ovr_flag", {255'd0, err_overrun}, 256'd1);
    chk("ovr_key", key_out, k2);
    chk("ovr_kv", {255'd0, key_valid}, 256'd1);

    // Handshake: start together with key_ack in DONE goes to IDLE
    start   = 1'b1;
    key_ack = 1'b1;
    tick();
    start   = 1'b0;
    key_ack = 1'b0;
    chk("hs_kv", {255'd0, key_valid}, 256'd0);
    chk("hs_busy", {255'd0, busy}, 256'd0);
    tick();
    chk("hs_busy2", {255'd0, busy}, 256'd0);
    chk("ovr_sticky", {255'd0, err_overrun}, 256'd1);

    // key_ack in ARMED has no effect
    start = 1'b1;
    tick();
    start   = 1'b0;
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    chk("ack_armed_busy", {255'd0, busy}, 256'd1);

    // Watchdog: 5 symbols then 16 idle cycles
    kv_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sym_valid = 1'b1;
      sym       = k1[2*i +: 2];
      tick();
      kv_seen = kv_seen | key_valid;
    end
    sym_valid = 1'b0;
    repeat (15) begin
      tick();
      kv_seen = kv_seen | key_valid;
    end
    chk("wd_busy15", {255'd0, busy}, 256'd1);
    chk("wd_egap15", {255'd0, err_gap}, 256'd0);
    tick();
    kv_seen = kv_seen | key_valid;
    chk("wd_busy16", {255'd0, busy}, 256'd0);
    chk("wd_egap16", {255'd0, err_gap}, 256'd1);
    repeat (3) begin
      tick();
      kv_seen = kv_seen | key_valid;
    end
    chk("wd_kv_never", {255'd0, kv_seen}, 256'd0);
    chk("wd_egap_sticky", {255'd0, err_gap}, 256'd1);

    // Reset mid-frame, then a fresh frame
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      sym_valid = 1'b1;
      sym       = k1[2*i +: 2];
      tick();
    end
    sym_valid = 1'b0;
    rst_all_n = 1'b0;
    tick();
    chk("mid_rst_key", key_out, 256'd0);
    chk("mid_rst_busy", {255'd0, busy}, 256'd0);
    chk("mid_rst_egap", {255'd0, err_gap}, 256'd0);
    chk("mid_rst_eovr", {255'd0, err_overrun}, 256'd0);
    rst_all_n = 1'b1;
    tick();
    send_frame(k2, 0);
    chk("k2_kv", {255'd0, key_valid}, 256'd1);
    chk("k2_key", key_out, k2);
    do_ack();
    chk("k2_ack_kv", {255'd0, key_valid}, 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/leak_collector_256.md
LEAK_COLLECTOR_256 -- requirements
Module: leak_collector_256

Interface
REQ-001 Parameter NSYM, default 128: number of 2-bit symbols per key frame (256 bits / 2).
REQ-002 Parameter GAP_MAX, default 16: maximum idle cycles allowed between valid symbols while collecting.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst_all_n, input, 1: reset, synchronous, active-low.
REQ-005 Port start, input, 1: arm request; accepted only in IDLE.
REQ-006 Port sym_valid, input, 1: a leaked symbol is present on sym this cycle.
REQ-007 Port sym, input, 2: leaked symbol; symbol 0 carries key bits [1:0].
REQ-008 Port key_ack, input, 1: consumer accepts key_out.
REQ-009 Port key_out, output, 256: reassembled key.
REQ-010 Port key_valid, output, 1: key_out complete and stable.
REQ-011 Port busy, output, 1: high in ARMED or COLLECT.
REQ-012 Port err_gap, output, 1: sticky; a frame was aborted by the gap watchdog.
REQ-013 Port err_overrun, output, 1: sticky; sym_valid seen in DONE.

Function
REQ-014 The FSM SHALL have states IDLE, ARMED, COLLECT and DONE.
REQ-015 IDLE: start=1 -> ARMED; clear the symbol counter, gap counter and key shift register.
REQ-016 ARMED: a cycle with sym_valid=1 SHALL shift the symbol in, set count=1 and move to COLLECT; waiting in ARMED has no timeout.
REQ-017 On each valid symbol, the shift register SHALL update as key <= {sym, key[255:2]}.
- After NSYM shifts, symbol i occupies key[2i+1:2i].
REQ-018 COLLECT: each valid symbol SHALL increment the 8-bit count and clear the gap counter.
- Each invalid cycle SHALL increment the gap counter.
REQ-019 When the NSYM-th symbol is sampled, the FSM SHALL enter DONE.
- key_valid SHALL assert on the following cycle: 1-cycle latency from the last symbol edge.
REQ-020 COLLECT: if the gap counter reaches GAP_MAX, the FSM SHALL abort to IDLE and set err_gap; the partial key is discarded.
REQ-021 DONE: key_valid=1 and key_out SHALL be held constant until key_ack=1; then the FSM goes to IDLE and key_valid deasserts on the next cycle.
REQ-022 DONE: sym_valid=1 SHALL set err_overrun, and the symbol SHALL be ignored.
REQ-023 start SHALL be ignored outside IDLE, including when it coincides with key_ack in DONE.
REQ-024 key_ack outside DONE SHALL have no effect.
REQ-025 The count SHALL never wrap: a symbol arriving in the same cycle as the transition to DONE is impossible by construction, because the transition is registered.
REQ-026 key_out SHALL reflect the live shift register in all states; it is meaningful only while key_valid=1.
REQ-027 err_gap and err_overrun SHALL clear only on reset.

Reset
REQ-028 While rst_all_n=0 at a clock edge, the block SHALL enter IDLE and set to zero: key register, counters, key_valid, busy, err_gap and err_overrun.
REQ-029 Reset asserted mid-frame SHALL discard all collected symbols; the frame is not resumable.

Structure
REQ-030 A shared package SHALL hold: the FSM state enum (2 bits), the KEY_W=256 and SYM_W=2 constants, and the NSYM default.
REQ-031 One sub-module, leak_shift_reg, SHALL implement the 256-bit right-shifting symbol register with shift-enable and synchronous clear.
- The FSM and counters SHALL live in the top module.

Verification
REQ-032 Full frame: reset, start=1, then 128 consecutive valid symbols carrying bits of K=256'h0123..CDEF.
- Required: key_valid=1 one cycle after symbol 127, key_out==K, busy=0.
REQ-033 Gappy frame: same K with 3 idle cycles inserted after every 10th symbol.
- Required: key_out==K, err_gap=0.
REQ-034 Watchdog: start, 5 valid symbols, then 16 idle cycles.
- Required: FSM returns to IDLE, err_gap=1, key_valid never asserts.
REQ-035 Overrun: complete a frame, then drive sym_valid=1 for 2 cycles before key_ack.
- Required: err_overrun=1, key_out unchanged.
REQ-036 Reset mid-frame: pull rst_all_n low after 60 symbols, then run a fresh full frame with K2=256'hFFFF_0000...
- Required: key_out==K2 with no residue from the first frame.
REQ-037 Handshake: assert start together with key_ack in DONE.
- Required: FSM goes to IDLE (not ARMED), and key_valid is 0 on the next cycle.
